// File: rtl/pll_rst_pkg.sv
// Shared state encoding, default timing constants and helpers for the PLL
// reset sequencer.
package pll_rst_pkg;

   typedef enum logic [1:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN
   } state_t;

   localparam int unsigned DEF_PLL_RST_CYCLES      = 10;
   localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
   localparam int unsigned DEF_SYNC_STAGES         = 2;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == '1) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the system reset; re-sequences on lock loss, timeout or request.
module pll_rst_ctrl
   import pll_rst_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
   parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       sw_rst_req,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic [7:0] lock_loss_cnt,
   output logic [7:0] timeout_cnt
);

   localparam int unsigned CNT_MAX = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                     PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
   localparam int unsigned TMR_W   = $clog2(LOCK_TIMEOUT_CYCLES) + 1;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic [7:0]       loss_nxt, tmo_nxt;
   logic             locked_s;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tmr_nxt   = '0;
      loss_nxt  = lock_loss_cnt;
      tmo_nxt   = timeout_cnt;
      case (state)
         PLL_RST: begin
            if (cnt == RST_LAST) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT_LOCK, STABLE: begin
            // Timeout is checked first so it wins over a same-cycle STABLE completion.
            tmr_nxt = tmr + 1'b1;
            if (tmr == TMO_LAST) begin
               state_nxt = PLL_RST;
               cnt_nxt   = '0;
               tmr_nxt   = '0;
               tmo_nxt   = sat_inc(timeout_cnt);
            end else if (sw_rst_req) begin
               state_nxt = PLL_RST;
               cnt_nxt   = '0;
               tmr_nxt   = '0;
            end else if (state == WAIT_LOCK) begin
               if (locked_s) begin
                  state_nxt = STABLE;
                  cnt_nxt   = '0;
               end
            end else if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
               tmr_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_nxt = PLL_RST;
               cnt_nxt   = '0;
               loss_nxt  = sat_inc(lock_loss_cnt);
            end else if (sw_rst_req) begin
               state_nxt = PLL_RST;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = PLL_RST;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the transition edge.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state         <= PLL_RST;
         cnt           <= '0;
         tmr           <= '0;
         lock_loss_cnt <= '0;
         timeout_cnt   <= '0;
         pll_rst       <= 1'b1;
         sys_rst_n     <= 1'b0;
         ready         <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         tmr           <= tmr_nxt;
         lock_loss_cnt <= loss_nxt;
         timeout_cnt   <= tmo_nxt;
         pll_rst       <= (state_nxt == PLL_RST);
         sys_rst_n     <= (state_nxt == RUN);
         ready         <= (state_nxt == RUN);
      end
   end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Self-checking bench for pll_rst_ctrl with short timing parameters.
module tb_pll_rst_ctrl;

   localparam int unsigned P_RST = 4;
   localparam int unsigned P_STB = 8;
   localparam int unsigned P_TMO = 32;
   localparam int unsigned P_SYN = 2;

   logic       refclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       sw_rst_req = 1'b0;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic [7:0] lock_loss_cnt;
   logic [7:0] timeout_cnt;

   pll_rst_ctrl #(
      .PLL_RST_CYCLES      (P_RST),
      .LOCK_STABLE_CYCLES  (P_STB),
      .LOCK_TIMEOUT_CYCLES (P_TMO),
      .SYNC_STAGES         (P_SYN)
   ) dut (
      .refclk        (refclk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .sw_rst_req    (sw_rst_req),
      .pll_rst       (pll_rst),
      .sys_rst_n     (sys_rst_n),
      .ready         (ready),
      .lock_loss_cnt (lock_loss_cnt),
      .timeout_cnt   (timeout_cnt)
   );

   always #10 refclk = ~refclk;

   typedef struct {
      string name;
      int    val;
      int    tol;
   } exp_t;

   typedef struct {
      int lock_delay;
      int exp_latency;
      int exp_tmo_inc;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[4];
   int   checks = 0;
   int   failures = 0;
   int   bad_cnt = 0;
   int   rise_cnt = 0;

   always @(negedge refclk)
      if ((sys_rst_n !== ready) || (pll_rst && sys_rst_n)) bad_cnt++;

   always @(posedge pll_rst) rise_cnt++;

   initial begin
      #5ms;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp_v);
      end
   endtask

   task automatic expect_val(input string name, input int v, input int tol);
      exp_t e;
      e.name = name;
      e.val  = v;
      e.tol  = tol;
      sb.push_back(e);
   endtask

   task automatic observe(input int act);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL sb_underflow act=%0d exp=queued", act);
      end else begin
         e = sb.pop_front();
         if ((act > e.val + e.tol) || (act + e.tol < e.val)) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d tol=%0d", e.name, act, e.val, e.tol);
         end
      end
   endtask

   task automatic measure_width(output int w);
      w = 0;
      while (pll_rst && w < 100) begin
         w++;
         @(negedge refclk);
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 400) begin
         @(negedge refclk);
         n++;
      end
   endtask

   // Called at a negedge while in RUN: request re-reset and drop the lock together.
   task automatic sw_pulse_drop();
      pll_locked = 1'b0;
      sw_rst_req = 1'b1;
      @(negedge refclk);
      sw_rst_req = 1'b0;
   endtask

   int w, n, k, cyc, last_rise, high_seen, tmo_before, rises_before;
   int loss_exp, tmo_exp;
   logic prev;

   initial begin
      vecs[0] = '{0, 11, 0};
      vecs[1] = '{3, 11, 0};
      vecs[2] = '{20, 11, 0};
      vecs[3] = '{21, 24, 1};
      loss_exp = 0;
      tmo_exp  = 0;

      // reset state
      repeat (3) @(negedge refclk);
      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_sys_rst_n", int'(sys_rst_n), 0);
      chk("rst_ready", int'(ready), 0);
      chk("rst_loss_cnt", int'(lock_loss_cnt), 0);
      chk("rst_tmo_cnt", int'(timeout_cnt), 0);

      // first bring-up: lock 3 cycles after pll_rst falls
      rst_n = 1'b1;
      expect_val("bringup_width", P_RST, 0);
      measure_width(w);
      observe(w);
      repeat (3) @(negedge refclk);
      pll_locked = 1'b1;
      expect_val("bringup_latency", P_SYN + P_STB + 1, 1);
      wait_ready(n);
      observe(n);
      chk("bringup_sys_rst_n", int'(sys_rst_n), 1);
      chk("bringup_pll_rst", int'(pll_rst), 0);

      // table: software re-reset then lock after varying delays
      foreach (vecs[i]) begin
         tmo_before = timeout_cnt;
         sw_pulse_drop();
         chk($sformatf("v%0d_sys_rst_n_low", i), int'(sys_rst_n), 0);
         expect_val($sformatf("v%0d_width", i), P_RST, 0);
         measure_width(w);
         observe(w);
         repeat (vecs[i].lock_delay) @(negedge refclk);
         pll_locked = 1'b1;
         expect_val($sformatf("v%0d_latency", i), vecs[i].exp_latency, 0);
         expect_val($sformatf("v%0d_tmo_inc", i), vecs[i].exp_tmo_inc, 0);
         wait_ready(n);
         observe(n);
         observe(int'(timeout_cnt) - tmo_before);
         tmo_exp += vecs[i].exp_tmo_inc;
      end
      chk("table_loss_cnt", int'(lock_loss_cnt), loss_exp);

      // lock glitch during STABLE restarts the stable count without a PLL re-pulse
      sw_pulse_drop();
      measure_width(w);
      pll_locked = 1'b1;
      repeat (5) @(negedge refclk);
      rises_before = rise_cnt;
      pll_locked = 1'b0;
      @(negedge refclk);
      pll_locked = 1'b1;
      expect_val("glitch_latency", P_SYN + P_STB + 1, 1);
      wait_ready(n);
      observe(n);
      chk("glitch_no_repulse", rise_cnt - rises_before, 0);
      chk("glitch_tmo_cnt", int'(timeout_cnt), tmo_exp);

      // single-cycle lock loss in RUN
      pll_locked = 1'b0;
      @(negedge refclk);
      n = 1;
      pll_locked = 1'b1;
      while (sys_rst_n && n < 20) begin
         @(negedge refclk);
         n++;
      end
      expect_val("loss_reaction", 2, 1);
      observe(n);
      loss_exp++;
      chk("loss_cnt_1", int'(lock_loss_cnt), loss_exp);
      expect_val("loss_width", P_RST, 0);
      measure_width(w);
      observe(w);
      expect_val("loss_relock", P_STB + 1, 1);
      wait_ready(n);
      observe(n);

      // no lock: periodic timeouts
      sw_pulse_drop();
      cyc = 0; last_rise = 0; k = 0; high_seen = 0; prev = pll_rst;
      while (k < 3 && cyc < 200) begin
         @(negedge refclk);
         cyc++;
         if (sys_rst_n) high_seen++;
         if (pll_rst && !prev) begin
            k++;
            tmo_exp++;
            chk($sformatf("tmo_period_%0d", k), cyc - last_rise, P_RST + P_TMO);
            chk($sformatf("tmo_cnt_%0d", k), int'(timeout_cnt), tmo_exp);
            last_rise = cyc;
         end
         prev = pll_rst;
      end
      chk("tmo_rises", k, 3);
      chk("tmo_sys_rst_n_low", high_seen, 0);
      pll_locked = 1'b1;
      expect_val("tmo_recover", P_RST + 1 + P_STB, 1);
      wait_ready(n);
      observe(n);

      // lock-loss counter saturation
      for (int i = 0; i < 258; i++) begin
         pll_locked = 1'b0;
         @(negedge refclk);
         pll_locked = 1'b1;
         n = 0;
         while (ready && n < 10) begin
            @(negedge refclk);
            n++;
         end
         wait_ready(n);
         loss_exp = (loss_exp == 255) ? 255 : loss_exp + 1;
         chk($sformatf("sat_loss_%0d", i), int'(lock_loss_cnt), loss_exp);
      end
      chk("sat_ready", int'(ready), 1);

      // software request during PLL_RST does not stretch the pulse
      sw_pulse_drop();
      sw_rst_req = 1'b1;
      @(negedge refclk);
      sw_rst_req = 1'b0;
      expect_val("sw_in_pllrst_width", P_RST, 0);
      measure_width(w);
      observe(w + 1);
      chk("sw_in_pllrst_loss", int'(lock_loss_cnt), 255);
      pll_locked = 1'b1;
      wait_ready(n);
      chk("sw_in_pllrst_ready", int'(ready), 1);

      // synchronous reset from RUN
      rst_n = 1'b0;
      @(negedge refclk);
      chk("rerst_sys_rst_n", int'(sys_rst_n), 0);
      chk("rerst_pll_rst", int'(pll_rst), 1);
      chk("rerst_ready", int'(ready), 0);
      chk("rerst_loss_cnt", int'(lock_loss_cnt), 0);
      chk("rerst_tmo_cnt", int'(timeout_cnt), 0);
      @(negedge refclk);
      rst_n = 1'b1;
      expect_val("rerst_width", P_RST, 0);
      measure_width(w);
      observe(w);
      expect_val("rerst_relock", P_STB + 1, 1);
      wait_ready(n);
      observe(n);

      chk("sb_leftover", sb.size(), 0);
      chk("out_consistency", bad_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
